// File: rtl/gpr_file_sb_pkg.sv
// rtl/gpr_file_sb_pkg.sv - shared flag-op encodings and defaults for the GPR file
package gpr_file_sb_pkg;

   typedef enum logic [1:0] {
      FLAG_OP_DIS        = 2'b00,
      FLAG_OP_SET        = 2'b01,
      FLAG_OP_SET_AND_WR = 2'b10,
      FLAG_OP_OR_AND_WR  = 2'b11
   } flag_op_t;

   localparam int FLAG_ADDR_DEFAULT = 31;

   // A pure SET is a flag-only operation; every other mode lets the GPR write through.
   function automatic logic op_writes_gpr(input logic [1:0] op);
      return op != FLAG_OP_SET;
   endfunction

   function automatic logic op_updates_flag(input logic [1:0] op);
      return op != FLAG_OP_DIS;
   endfunction

endpackage

// File: rtl/gpr_file_sb_scoreboard.sv
// rtl/gpr_file_sb_scoreboard.sv - pending-write busy bits and RAW/WAW stall generation
module gpr_scoreboard #(
   parameter int ADDR_W = 5,
   parameter int BYPASS = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_W-1:0]     a1,
   input  logic [ADDR_W-1:0]     a2,
   input  logic                  re1,
   input  logic                  re2,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     awr,
   input  logic                  iss_valid,
   input  logic [ADDR_W-1:0]     iss_addr,
   output logic                  stall,
   output logic [2**ADDR_W-1:0]  busy
);

   localparam int   NREG = 2**ADDR_W;
   localparam logic BP   = (BYPASS != 0);

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_next;
   logic            clr1;
   logic            clr2;
   logic            clri;

   // A writeback in flight this cycle releases its register early only when bypassing.
   assign clr1 = BP && we && (awr == a1);
   assign clr2 = BP && we && (awr == a2);
   assign clri = BP && we && (awr == iss_addr);

   assign stall = (re1 && busy_q[a1] && !clr1)
               || (re2 && busy_q[a2] && !clr2)
               || (iss_valid && busy_q[iss_addr] && !clri);

   always_comb begin
      busy_next = busy_q;
      if (we && (awr != '0))
         busy_next[awr] = 1'b0;
      // Set is applied after clear so the newer writer keeps ownership.
      if (iss_valid && !stall && (iss_addr != '0))
         busy_next[iss_addr] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         busy_q <= '0;
      else
         busy_q <= busy_next;
   end

   assign busy = busy_q;

endmodule

// File: rtl/gpr_file_sb.sv
// rtl/gpr_file_sb.sv - parametrised GPR file with flag register, bypass and issue scoreboard
module gpr_file_sb
   import gpr_file_sb_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 5,
   parameter int FLAG_ADDR = FLAG_ADDR_DEFAULT,
   parameter int BYPASS    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_W-1:0]     a1,
   input  logic [ADDR_W-1:0]     a2,
   input  logic                  re1,
   input  logic                  re2,
   output logic [DATA_W-1:0]     rd1,
   output logic [DATA_W-1:0]     rd2,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     awr,
   input  logic [DATA_W-1:0]     din,
   input  logic [1:0]            flag_op,
   input  logic [DATA_W-1:0]     nflag,
   output logic [DATA_W-1:0]     flag,
   input  logic                  iss_valid,
   input  logic [ADDR_W-1:0]     iss_addr,
   output logic                  stall,
   output logic [2**ADDR_W-1:0]  busy
);

   localparam int                NREG     = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] FLAG_IDX = ADDR_W'(FLAG_ADDR);
   localparam logic              BP       = (BYPASS != 0);

   logic [DATA_W-1:0] regs [NREG];
   logic              wr_gpr;
   logic              flag_upd;
   logic              flag_hit;
   logic [DATA_W-1:0] flag_next;
   logic              fwd;
   logic [DATA_W-1:0] fwd_val;

   assign wr_gpr    = we && (awr != '0) && op_writes_gpr(flag_op);
   assign flag_upd  = op_updates_flag(flag_op);
   assign flag_hit  = (awr == FLAG_IDX) && flag_upd;
   assign flag_next = (flag_op == FLAG_OP_OR_AND_WR) ? (regs[FLAG_ADDR] | nflag) : nflag;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
      end else begin
         // The flag update owns FLAG_ADDR whenever both target it.
         if (wr_gpr && !flag_hit)
            regs[awr] <= din;
         if (flag_upd)
            regs[FLAG_ADDR] <= flag_next;
      end
   end

   // Forwarding is suppressed during reset so reads show the cleared array at once.
   assign fwd     = BP && wr_gpr && !reset;
   assign fwd_val = flag_hit ? flag_next : din;

   always_comb begin
      rd1 = regs[a1];
      if (fwd && (awr == a1))
         rd1 = fwd_val;
      if (a1 == '0)
         rd1 = '0;
   end

   always_comb begin
      rd2 = regs[a2];
      if (fwd && (awr == a2))
         rd2 = fwd_val;
      if (a2 == '0)
         rd2 = '0;
   end

   assign flag = regs[FLAG_ADDR];

   gpr_scoreboard #(
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
   ) u_scoreboard (
      .clk       (clk),
      .reset     (reset),
      .a1        (a1),
      .a2        (a2),
      .re1       (re1),
      .re2       (re2),
      .we        (we),
      .awr       (awr),
      .iss_valid (iss_valid),
      .iss_addr  (iss_addr),
      .stall     (stall),
      .busy      (busy)
   );

endmodule

// File: tb/tb_gpr_file_sb.sv
// tb/tb_gpr_file_sb.sv - checks bypass and non-bypass GPR files against a rule-level model
module tb_gpr_file_sb;

   localparam int         NR  = 32;
   localparam logic [4:0] FAI = 5'd31;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  a1, a2, awr, iss_addr;
   logic        re1, re2, we, iss_valid;
   logic [31:0] din, nflag;
   logic [1:0]  flag_op;

   logic [31:0] rd1_b1, rd2_b1, flag_b1, busy_b1;
   logic [31:0] rd1_b0, rd2_b0, flag_b0, busy_b0;
   logic        stall_b1, stall_b0;

   logic [31:0] m_reg  [2][NR];
   logic [31:0] m_busy [2];

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   gpr_file_sb #(.DATA_W(32), .ADDR_W(5), .FLAG_ADDR(31), .BYPASS(1)) u_byp (
      .clk(clk), .reset(reset), .a1(a1), .a2(a2), .re1(re1), .re2(re2),
      .rd1(rd1_b1), .rd2(rd2_b1), .we(we), .awr(awr), .din(din),
      .flag_op(flag_op), .nflag(nflag), .flag(flag_b1),
      .iss_valid(iss_valid), .iss_addr(iss_addr), .stall(stall_b1), .busy(busy_b1));

   gpr_file_sb #(.DATA_W(32), .ADDR_W(5), .FLAG_ADDR(31), .BYPASS(0)) u_nob (
      .clk(clk), .reset(reset), .a1(a1), .a2(a2), .re1(re1), .re2(re2),
      .rd1(rd1_b0), .rd2(rd2_b0), .we(we), .awr(awr), .din(din),
      .flag_op(flag_op), .nflag(nflag), .flag(flag_b0),
      .iss_valid(iss_valid), .iss_addr(iss_addr), .stall(stall_b0), .busy(busy_b0));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int b = 0; b < 2; b++) begin
         m_busy[b] = '0;
         for (int i = 0; i < NR; i++)
            m_reg[b][i] = '0;
      end
   endtask

   function automatic logic m_gpr_wr();
      return we && (awr != 5'd0) && (flag_op != 2'b01);
   endfunction

   function automatic logic [31:0] m_flag_next(input int b);
      return (flag_op == 2'b11) ? (m_reg[b][FAI] | nflag) : nflag;
   endfunction

   function automatic logic [31:0] e_rd(input int b, input logic [4:0] a);
      if (a == 5'd0)
         return 32'd0;
      if (b == 1 && m_gpr_wr() && awr == a)
         return (awr == FAI && flag_op != 2'b00) ? m_flag_next(b) : din;
      return m_reg[b][a];
   endfunction

   function automatic logic e_stall(input int b);
      logic c1, c2, ci;
      c1 = (b == 1) && we && (awr == a1);
      c2 = (b == 1) && we && (awr == a2);
      ci = (b == 1) && we && (awr == iss_addr);
      return (re1 && m_busy[b][a1] && !c1) || (re2 && m_busy[b][a2] && !c2)
          || (iss_valid && m_busy[b][iss_addr] && !ci);
   endfunction

   task automatic m_edge(input int b, input logic st);
      logic        wr, fu;
      logic [31:0] fn;
      wr = m_gpr_wr();
      fu = (flag_op != 2'b00);
      fn = m_flag_next(b);
      if (wr && !(awr == FAI && fu))
         m_reg[b][awr] = din;
      if (fu)
         m_reg[b][FAI] = fn;
      if (we && awr != 5'd0)
         m_busy[b][awr] = 1'b0;
      if (iss_valid && !st && iss_addr != 5'd0)
         m_busy[b][iss_addr] = 1'b1;
   endtask

   task automatic check_outputs(input string tag);
      for (int b = 0; b < 2; b++) begin
         chk($sformatf("%s.b%0d.rd1", tag, b), (b == 1) ? rd1_b1 : rd1_b0, e_rd(b, a1));
         chk($sformatf("%s.b%0d.rd2", tag, b), (b == 1) ? rd2_b1 : rd2_b0, e_rd(b, a2));
         chk($sformatf("%s.b%0d.flag", tag, b), (b == 1) ? flag_b1 : flag_b0, m_reg[b][FAI]);
         chk($sformatf("%s.b%0d.stall", tag, b), {31'd0, (b == 1) ? stall_b1 : stall_b0},
             {31'd0, e_stall(b)});
         chk($sformatf("%s.b%0d.busy", tag, b), (b == 1) ? busy_b1 : busy_b0, m_busy[b]);
      end
   endtask

   // Called just after a negedge with inputs already driven; returns at the next negedge.
   task automatic cycle(input string tag);
      logic st0, st1;
      #1;
      check_outputs(tag);
      st0 = e_stall(0);
      st1 = e_stall(1);
      @(posedge clk);
      m_edge(0, st0);
      m_edge(1, st1);
      @(negedge clk);
   endtask

   task automatic idle();
      a1 = 5'd0; a2 = 5'd0; re1 = 1'b0; re2 = 1'b0;
      we = 1'b0; awr = 5'd0; din = '0;
      flag_op = 2'b00; nflag = '0;
      iss_valid = 1'b0; iss_addr = 5'd0;
   endtask

   function automatic logic [4:0] rand_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r == 8) return FAI;
      if (r == 9) return 5'($urandom_range(0, 31));
      return 5'(r);
   endfunction

   initial begin
      idle();
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
         a1 = 5'(i);
         a2 = 5'(NR - 1 - i);
         #1;
         chk("rst.rd1", rd1_b1, 32'd0);
         chk("rst.rd2", rd2_b0, 32'd0);
      end
      chk("rst.busy", busy_b1 | busy_b0, 32'd0);
      chk("rst.flag", flag_b1 | flag_b0, 32'd0);
      chk("rst.stall", {31'd0, stall_b1 | stall_b0}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      idle();
      cycle("post_rst");

      we = 1'b1; awr = 5'd5; din = 32'hDEAD_BEEF; a1 = 5'd5;
      #1;
      chk("byp.same_cycle", rd1_b1, 32'hDEAD_BEEF);
      chk("nobyp.same_cycle", rd1_b0, 32'd0);
      cycle("wr5");
      idle(); a1 = 5'd5;
      #1;
      chk("wr5.next.b1", rd1_b1, 32'hDEAD_BEEF);
      chk("wr5.next.b0", rd1_b0, 32'hDEAD_BEEF);
      cycle("rd5");

      we = 1'b1; awr = 5'd0; din = 32'd1; a1 = 5'd0;
      cycle("wr0");
      idle(); a1 = 5'd0; iss_valid = 1'b1; iss_addr = 5'd0;
      cycle("iss0");
      idle();
      #1;
      chk("iss0.busy", busy_b1, 32'd0);
      cycle("iss0.after");

      flag_op = 2'b01; nflag = 32'h1;
      cycle("flag.set1");
      flag_op = 2'b11; nflag = 32'h4;
      cycle("flag.or4");
      idle();
      #1;
      chk("flag.sticky", flag_b1, 32'h5);
      flag_op = 2'b01; nflag = 32'h0;
      cycle("flag.set0");
      idle();
      #1;
      chk("flag.cleared", flag_b0, 32'h0);

      we = 1'b1; awr = FAI; din = 32'd7; flag_op = 2'b10; nflag = 32'd9; a1 = FAI;
      #1;
      chk("collide.fwd", rd1_b1, 32'd9);
      cycle("collide");
      idle(); a1 = FAI;
      #1;
      chk("collide.flag", flag_b1, 32'd9);
      chk("collide.rd", rd1_b0, 32'd9);
      cycle("collide.after");

      iss_valid = 1'b1; iss_addr = 5'd3;
      cycle("iss3");
      idle(); re1 = 1'b1; a1 = 5'd3;
      #1;
      chk("raw.stall.b1", {31'd0, stall_b1}, 32'd1);
      chk("raw.stall.b0", {31'd0, stall_b0}, 32'd1);
      cycle("raw.hold");
      we = 1'b1; awr = 5'd3; din = 32'h33;
      #1;
      chk("clr.unstall.b1", {31'd0, stall_b1}, 32'd0);
      chk("clr.stall.b0", {31'd0, stall_b0}, 32'd1);
      cycle("clr3");
      idle(); re1 = 1'b1; a1 = 5'd3;
      #1;
      chk("clr.unstall.b0", {31'd0, stall_b0}, 32'd0);
      cycle("clr3.after");
      idle(); iss_valid = 1'b1; iss_addr = 5'd3;
      cycle("iss3.again");
      we = 1'b1; awr = 5'd3; iss_valid = 1'b1; iss_addr = 5'd3;
      cycle("set_clr3");
      idle();
      #1;
      chk("set_wins.busy3", {31'd0, busy_b1[3]}, 32'd1);
      cycle("set_clr3.after");

      we = 1'b1; awr = 5'd7; din = 32'hAAAA_5555;
      cycle("wr7");
      idle(); iss_valid = 1'b1; iss_addr = 5'd7;
      cycle("iss7");
      idle(); we = 1'b1; awr = 5'd7; din = 32'h1234; a1 = 5'd7;
      #2;
      reset = 1'b1;
      #1;
      chk("midrst.busy.b1", busy_b1, 32'd0);
      chk("midrst.busy.b0", busy_b0, 32'd0);
      chk("midrst.rd7.b1", rd1_b1, 32'd0);
      chk("midrst.rd7.b0", rd1_b0, 32'd0);
      chk("midrst.stall", {31'd0, stall_b1 | stall_b0}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      idle(); a1 = 5'd7;
      #1;
      chk("midrst.nowrite", rd1_b1 | rd1_b0, 32'd0);
      cycle("midrst.after");

      for (int n = 0; n < 400; n++) begin
         a1 = rand_addr(); a2 = rand_addr();
         re1 = 1'($urandom_range(0, 1)); re2 = 1'($urandom_range(0, 1));
         we = 1'($urandom_range(0, 1)); awr = rand_addr(); din = $urandom();
         flag_op = 2'($urandom_range(0, 3)); nflag = $urandom();
         iss_valid = 1'($urandom_range(0, 1)); iss_addr = rand_addr();
         cycle($sformatf("rnd%0d", n));
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
